// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures a slow clock-like signal that is asynchronous to clk, for example
// the output of a clock divider. For each completed cycle of sig_in the block
// reports the period and the high time, both counted in clk cycles, and pulses
// valid for one cycle. If no rising edge arrives within TIMEOUT cycles, the
// sticky timeout flag is raised and the block re-arms.
//
// Parameters
//   CNT_W    width of the cycle counter and of period/high_time
//   TIMEOUT  cycles without a rising edge before timeout (2 .. 2^CNT_W-1)
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   en         measurement enable (synchronous, level-sensitive)
//   sig_in     measured signal, asynchronous to clk
//   period     clk cycles between the last two detected rising edges
//   high_time  clk cycles sig_in was high within that period
//   valid      one-cycle pulse when period/high_time update
//   timeout    sticky: no rising edge within TIMEOUT cycles
//   busy       high while armed or measuring
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state;
    state_t           next_state;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcap;
    logic             at_limit;
    logic             do_meas;

    // s1/s2 resolve metastability; s3 is the delayed copy used for edge
    // detection. Every edge is seen with the same latency, so it cancels
    // out of the measured differences.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign cnt_inc  = cnt + 1'b1;
    assign at_limit = (cnt_inc == TIMEOUT_C);
    // A rise always wins over a simultaneous timeout threshold.
    assign do_meas  = en && (state == MEASURE) && rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        if (!en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = ARM;
                ARM:     if (rise) next_state = MEASURE;
                MEASURE: if (!rise && at_limit) next_state = ARM;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            hcap      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= do_meas;
            busy  <= (next_state != IDLE);

            if (!en) begin
                // Disabling aborts the measurement; results are kept.
                cnt     <= '0;
                hcap    <= '0;
                timeout <= 1'b0;
            end else if (state == MEASURE) begin
                if (rise) begin
                    period    <= cnt_inc;
                    high_time <= hcap;
                    timeout   <= 1'b0;
                    cnt       <= '0;
                end else if (at_limit) begin
                    timeout <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
                // fall and rise are mutually exclusive, so this never
                // collides with the capture above.
                if (fall) begin
                    hcap <= cnt_inc;
                end
            end else begin
                // IDLE and ARM keep the counter parked at zero; the first
                // rise in ARM starts counting from here.
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//
// Two instances share sig_in and reset: dut_a (TIMEOUT=64) covers the main
// function, reset, timeout and enable abort; dut_b (TIMEOUT=20) covers a rise
// landing on the timeout threshold cycle. sig_in is driven on the falling
// edge of clk so phase lengths are exact clk-cycle counts. Each rising edge
// of sig_in that should complete a measurement pushes the hand-computed
// period/high time of the preceding sig_in cycle into a per-instance queue;
// a monitor per instance pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int CNT_W = 28;

    typedef struct {
        int per;
        int hi;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en_a;
    logic             en_b;
    logic             sig_in;

    logic [CNT_W-1:0] period_a;
    logic [CNT_W-1:0] high_time_a;
    logic             valid_a;
    logic             timeout_a;
    logic             busy_a;

    logic [CNT_W-1:0] period_b;
    logic [CNT_W-1:0] high_time_b;
    logic             valid_b;
    logic             timeout_b;
    logic             busy_b;

    exp_t q_a[$];
    exp_t q_b[$];
    bit   to_b   = 1'b0;
    int   prev_h = 0;
    int   prev_l = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(64)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .en        (en_a),
        .sig_in    (sig_in),
        .period    (period_a),
        .high_time (high_time_a),
        .valid     (valid_a),
        .timeout   (timeout_a),
        .busy      (busy_a)
    );

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(20)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .en        (en_b),
        .sig_in    (sig_in),
        .period    (period_b),
        .high_time (high_time_b),
        .valid     (valid_b),
        .timeout   (timeout_b),
        .busy      (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int per, input int hi);
        exp_t e;
        e.per = per;
        e.hi  = hi;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    // One sig_in cycle: h cycles high then l cycles low. Called at a falling
    // edge and returns at a falling edge. The rise at the start completes the
    // measurement of the previous cycle when exp is set.
    task automatic pulse(input int h, input int l, input bit exp);
        if (exp) push_exp(prev_h + prev_l, prev_h);
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
        prev_h = h;
        prev_l = l;
    endtask

    // Monitors: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && valid_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'(valid_a), 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_period", 32'(period_a), e.per);
                check("a_high_time", 32'(high_time_a), e.hi);
                check("a_timeout_on_valid", 32'(timeout_a), 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && valid_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", 32'(valid_b), 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_period", 32'(period_b), e.per);
                check("b_high_time", 32'(high_time_b), e.hi);
                check("b_timeout_on_valid", 32'(timeout_b), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset  = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_period", 32'(period_a), 32'd0);
        check("rst_high_time", 32'(high_time_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_timeout", 32'(timeout_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 50% duty, 20-cycle period: first rise only arms.
        en_a = 1'b1;
        pulse(10, 10, 1'b0);
        pulse(10, 10, 1'b1);
        pulse(10, 10, 1'b1);
        pulse(10, 10, 1'b1);
        check("busy_measure", 32'(busy_a), 32'd1);

        // Reset in the middle of a measurement while sig_in is high.
        push_exp(prev_h + prev_l, prev_h);
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_period", 32'(period_a), 32'd0);
        check("midrst_high_time", 32'(high_time_a), 32'd0);
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_timeout", 32'(timeout_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        en_a   = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(5, 5, 1'b0);
            check("idle_busy", 32'(busy_a), 32'd0);
        end

        // 25% duty, 40-cycle period, then a transitional 22-cycle period
        // (10 high / 12 low) before settling at 24 (12/12).
        en_a = 1'b1;
        pulse(10, 30, 1'b0);
        pulse(10, 30, 1'b1);
        pulse(10, 30, 1'b1);
        pulse(10, 12, 1'b1);
        pulse(12, 12, 1'b1);
        pulse(12, 12, 1'b1);
        pulse(12, 12, 1'b1);

        // Timeout: one more rise, then sig_in stays low. The rise is
        // registered on the third clk edge after it is driven, so the flag
        // appears 64 cycles later, on the 67th edge.
        push_exp(prev_h + prev_l, prev_h);
        sig_in = 1'b1;
        for (int i = 1; i <= 67; i++) begin
            @(negedge clk);
            if (i == 10) sig_in = 1'b0;
            if (i == 66) check("timeout_early", 32'(timeout_a), 32'd0);
        end
        check("timeout_set", 32'(timeout_a), 32'd1);
        check("timeout_period_held", 32'(period_a), 32'd24);
        check("timeout_high_held", 32'(high_time_a), 32'd12);
        check("timeout_busy", 32'(busy_a), 32'd1);

        // Restart: first rise re-arms only, second rise measures.
        pulse(10, 10, 1'b0);
        check("rearm_timeout_sticky", 32'(timeout_a), 32'd1);
        pulse(10, 10, 1'b1);
        check("restart_timeout_clear", 32'(timeout_a), 32'd0);

        // Enable abort mid-period.
        pulse(10, 5, 1'b1);
        en_a = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_timeout", 32'(timeout_a), 32'd0);
        check("abort_period_held", 32'(period_a), 32'd20);
        en_a = 1'b1;
        @(negedge clk);
        check("abort_rearm_busy", 32'(busy_a), 32'd1);
        pulse(10, 10, 1'b0);
        pulse(10, 10, 1'b1);

        // Minimum phases: 2 high / 2 low.
        pulse(2, 2, 1'b1);
        for (int i = 0; i < 4; i++) pulse(2, 2, 1'b1);
        en_a = 1'b0;

        // Rise coinciding with the threshold cycle on the TIMEOUT=20 unit.
        to_b = 1'b1;
        en_b = 1'b1;
        @(negedge clk);
        pulse(10, 10, 1'b0);
        pulse(10, 10, 1'b1);
        pulse(10, 10, 1'b1);
        check("b_boundary_timeout", 32'(timeout_b), 32'd0);
        check("b_boundary_busy", 32'(busy_b), 32'd1);
        en_b = 1'b0;

        repeat (10) @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
